wdt_bus_ctrl: RTL
=================

# wdt_bus_ctrl

Bus-side controller for the watchdog timer: decodes 8-bit I/O accesses into the watchdog's byte-lane write strobes and data, makes 16-bit counter and reload accesses atomic, and guards all watchdog writes behind a key-sequence unlock. It also provides a key-sequence "kick" that reloads the counter. It sits between the CPU I/O bus and the watchdog. Its `key_violation` output is ORed into the watchdog `trap` input at top level.

## Interface
Parameters:
- `WINDOW`, default 16: number of cycles a protected-write window stays open after unlock; legal range 1–255.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; driven from the watchdog `reset` output.
- `addr` input 3: I/O register address.
- `wdata` input 8: write data.
- `wr` input 1: write strobe, one cycle per access.
- `rd` input 1: read strobe, one cycle per access.
- `rdata` output 8: registered read data.
- `counter_out` input 16: current watchdog counter.
- `reload_out` input 16: current watchdog reload value.
- `config_out` input 8: current watchdog config.
- `counter_in` output 16: counter write data.
- `reload_in` output 16: reload write data.
- `config_in` output 8: config write data.
- `counter_write` output 2: counter byte-lane strobes.
- `reload_write` output 2: reload byte-lane strobes.
- `config_write` output 1: config strobe.
- `key_violation` output 1: one-cycle pulse on an illegal key or a locked write.

## Operation
Register map:
- 0 CNT_LO, 1 CNT_HI, 2 RLD_LO, 3 RLD_HI, 4 CFG, 5 KEY.
- Addresses 6–7 read 0x00; writes to them are ignored and raise no violation.

Atomic 16-bit writes:
- A LO write stores `wdata` in a per-register temp byte (`cnt_tmp` / `rld_tmp`). No strobe is issued.
- A HI write issues both lane strobes (2'b11), with data {wdata, tmp}.
- The temp byte persists until it is overwritten or reset.

Atomic 16-bit reads:
- Reading CNT_LO returns `counter_out[7:0]` and snapshots `counter_out[15:8]` into `cnt_snap`.
- Reading CNT_HI returns `cnt_snap`.
- RLD reads use the same scheme with their own snapshot.
- CFG reads return `config_out`.
- KEY reads return {6'b0, state code}: LOCKED=0, KEY1=1, OPEN=2.

Protection FSM (states LOCKED, KEY1, OPEN):
- LOCKED, KEY write 0x55 → KEY1.
- KEY1, KEY write 0xCC → OPEN; window counter loaded with `WINDOW`.
- KEY1, KEY write 0xAA → kick: `counter_in`=`reload_out`, `counter_write`=2'b11; → LOCKED.
- KEY1, any other KEY write → `key_violation`; → LOCKED.
- KEY1, any non-KEY write → treated as an ordinary write in LOCKED.
- LOCKED or KEY1, protected write (addr 0–4) → dropped, `key_violation`. The state is unchanged, except that KEY1 falls to LOCKED.
- LOCKED, KEY write other than 0x55 → `key_violation`.
- OPEN, writes to addr 0–4 → accepted. A HI or CFG write (a committing write) → LOCKED after issuing its strobe. LO writes do not relock.
- OPEN, window counter decrements each cycle; reaching 0 → LOCKED.
- OPEN, KEY write → LOCKED, no violation.

Bus rules:
- `wr` and `rd` high together: write wins, read ignored, `rdata` holds.
- Reads never change FSM state.

## Timing
- Write on edge N → strobes and data registered, high only during cycle N+1. The watchdog samples them at edge N+2.
- At most one strobe group is active per cycle. Strobes are zero in all other cycles.
- Read on edge N → `rdata` valid from N+1 and held until the next read.
- `key_violation` is registered: one-cycle pulse in cycle N+1.
- OPEN entered at edge N: the window allows writes on edges N+1 … N+WINDOW. The edge N+WINDOW both accepts the write and relocks.
- Window expiry coinciding with a committing write: the write is accepted, then LOCKED.
- Reset values: `rdata`=0, all strobes 0, `counter_in`/`reload_in`/`config_in`=0, `key_violation`=0, state LOCKED, temps and snapshots 0, window counter 0.
- Reset mid-window or mid-sequence → LOCKED at the next edge. A pending strobe is suppressed in the cycle following the reset edge.

## Configuration
- `WDT_CTRL_LOCK_EN` defined: protection FSM as above.
- Not defined:
  - Protected writes are always accepted.
  - KEY 0x55 then 0xAA still kicks.
  - 0xCC and illegal keys return the FSM to LOCKED silently.
  - `key_violation` is tied to 0.
  - KEY reads return 0x00 or 0x01.

## Test plan
- Unlock and atomic write: KEY←0x55, KEY←0xCC, CNT_LO←0x34, CNT_HI←0x12 → single cycle `counter_write`=2'b11, `counter_in`=0x1234; state then LOCKED.
- Locked write: CFG←0x01 from reset → `config_write` never asserts, `key_violation` pulses one cycle.
- Kick: `reload_out`=0xF000, KEY←0x55, KEY←0xAA → `counter_write`=2'b11, `counter_in`=0xF000; no violation.
- Bad key: KEY←0x55, KEY←0x12 → violation pulse, state LOCKED; a following CNT_HI write is dropped.
- Window expiry, WINDOW=4: unlock, idle 4 cycles, RLD_HI←0x77 → dropped, violation. With a write at exactly cycle 4 → accepted.
- Atomic read: `counter_out`=0xABCD, read CNT_LO → 0xCD; change `counter_out` to 0x0000, read CNT_HI → 0xAB.

Source files
------------

// File: rtl/wdt_bus_ctrl.sv
// wdt_bus_ctrl: CPU I/O bus front end for the watchdog timer.
// Decodes byte accesses into watchdog byte-lane strobes, makes 16-bit
// counter/reload accesses atomic through temp/snapshot bytes, and provides
// a key-sequence kick (0x55, 0xAA) that reloads the counter.
// Optional feature macro: WDT_CTRL_LOCK_EN enables the write-protection FSM
// (0x55, 0xCC unlock, WINDOW-cycle write window, key_violation pulses).
// Without it, protected writes are always accepted and key_violation stays 0.
module wdt_bus_ctrl #(
    parameter int WINDOW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        wr,
    input  logic        rd,
    output logic [7:0]  rdata,
    input  logic [15:0] counter_out,
    input  logic [15:0] reload_out,
    input  logic [7:0]  config_out,
    output logic [15:0] counter_in,
    output logic [15:0] reload_in,
    output logic [7:0]  config_in,
    output logic [1:0]  counter_write,
    output logic [1:0]  reload_write,
    output logic        config_write,
    output logic        key_violation
);

`ifdef WDT_CTRL_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_KEY1   = 2'd1,
        ST_OPEN   = 2'd2
    } state_t;

    state_t     state_r;
    logic [7:0] win_r;
    logic [7:0] cnt_tmp_r;
    logic [7:0] rld_tmp_r;
    logic [7:0] cnt_snap_r;
    logic [7:0] rld_snap_r;
    logic       wr_ok_s;

    // Protected registers are writable only inside the open window when locking is built in.
    assign wr_ok_s = (!LOCK_EN) || (state_r == ST_OPEN);

    // Protection FSM, write decode, read mux and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_LOCKED;
            win_r         <= 8'd0;
            cnt_tmp_r     <= 8'd0;
            rld_tmp_r     <= 8'd0;
            cnt_snap_r    <= 8'd0;
            rld_snap_r    <= 8'd0;
            rdata         <= 8'd0;
            counter_in    <= 16'd0;
            reload_in     <= 16'd0;
            config_in     <= 8'd0;
            counter_write <= 2'b00;
            reload_write  <= 2'b00;
            config_write  <= 1'b0;
            key_violation <= 1'b0;
        end else begin
            // Strobes and violation are single-cycle pulses.
            counter_write <= 2'b00;
            reload_write  <= 2'b00;
            config_write  <= 1'b0;
            key_violation <= 1'b0;

            // Window countdown: the edge that sees win_r == 1 is the last
            // accepting edge; a write on it still lands, then we relock.
            if (state_r == ST_OPEN) begin
                win_r <= win_r - 8'd1;
                if (win_r <= 8'd1) begin
                    state_r <= ST_LOCKED;
                end
            end

            if (wr) begin
                if ((addr <= 3'd4) && !wr_ok_s) begin
                    // Dropped protected write; a pending first key is abandoned.
                    key_violation <= 1'b1;
                    if (state_r == ST_KEY1) begin
                        state_r <= ST_LOCKED;
                    end
                end else begin
                    case (addr)
                        3'd0: begin
                            cnt_tmp_r <= wdata;
                            if (state_r == ST_KEY1) begin
                                state_r <= ST_LOCKED;
                            end
                        end
                        3'd1: begin
                            counter_in    <= {wdata, cnt_tmp_r};
                            counter_write <= 2'b11;
                            state_r       <= ST_LOCKED;
                        end
                        3'd2: begin
                            rld_tmp_r <= wdata;
                            if (state_r == ST_KEY1) begin
                                state_r <= ST_LOCKED;
                            end
                        end
                        3'd3: begin
                            reload_in    <= {wdata, rld_tmp_r};
                            reload_write <= 2'b11;
                            state_r      <= ST_LOCKED;
                        end
                        3'd4: begin
                            config_in    <= wdata;
                            config_write <= 1'b1;
                            state_r      <= ST_LOCKED;
                        end
                        3'd5: begin
                            case (state_r)
                                ST_LOCKED: begin
                                    if (wdata == 8'h55) begin
                                        state_r <= ST_KEY1;
                                    end else begin
                                        key_violation <= LOCK_EN;
                                    end
                                end
                                ST_KEY1: begin
                                    if (wdata == 8'hCC) begin
                                        if (LOCK_EN) begin
                                            state_r <= ST_OPEN;
                                            win_r   <= 8'(WINDOW);
                                        end else begin
                                            state_r <= ST_LOCKED;
                                        end
                                    end else if (wdata == 8'hAA) begin
                                        counter_in    <= reload_out;
                                        counter_write <= 2'b11;
                                        state_r       <= ST_LOCKED;
                                    end else begin
                                        key_violation <= LOCK_EN;
                                        state_r       <= ST_LOCKED;
                                    end
                                end
                                default: begin
                                    state_r <= ST_LOCKED;
                                end
                            endcase
                        end
                        default: begin
                            // Unused addresses: write ignored, no violation.
                        end
                    endcase
                end
            end else if (rd) begin
                case (addr)
                    3'd0: begin
                        rdata      <= counter_out[7:0];
                        cnt_snap_r <= counter_out[15:8];
                    end
                    3'd1: rdata <= cnt_snap_r;
                    3'd2: begin
                        rdata      <= reload_out[7:0];
                        rld_snap_r <= reload_out[15:8];
                    end
                    3'd3: rdata <= rld_snap_r;
                    3'd4: rdata <= config_out;
                    3'd5: rdata <= {6'd0, state_r};
                    default: rdata <= 8'd0;
                endcase
            end
        end
    end

endmodule
